// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg : shared UART state encoding, baud helper and board defaults.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_CLK_FREQ = 25_000_000;
  localparam int UART_BAUD     = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Truncating division: 25 MHz / 115200 yields 217 clocks per bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ---------------------------------------------------------------------------
// uart_tx_if : valid/ready byte handshake into the UART transmitter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_tx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen : bit-period counter with enable, sync clear and wrap tick.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 217
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_en,
  input  wire logic i_clr,
  output logic      o_tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == C_CNT_MAX);
  assign o_tick = i_en && w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : 8N1-style serial transmitter, LSB first, registered tx line.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = UART_CLK_FREQ,
  parameter int BAUD      = UART_BAUD,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  wire logic clk,
  input  wire logic rst,
  uart_tx_if.slave  s_if,
  output logic      o_tx,
  output logic      o_tx_busy,
  output logic      o_tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BIT_CNT_W    = $clog2(DATA_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] C_LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] C_LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_t            r_state;
  uart_state_t            w_state_next;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_next;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic [BIT_CNT_W-1:0]   w_bit_cnt_next;
  logic                   r_tx;
  logic                   w_tx_next;
  logic                   w_handshake;
  logic                   w_busy;
  logic                   w_tick;
  logic                   w_done;

  assign w_busy      = (r_state != IDLE);
  assign w_handshake = s_if.tx_valid && !w_busy;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_busy),
    .i_clr  (w_handshake),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_tx      <= w_tx_next;
    end
  end

  // The bit counter is reused in STOP to count stop bits.
  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_cnt_next = r_bit_cnt;
    w_done         = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_state_next   = START;
          w_shift_next   = s_if.tx_data;
          w_bit_cnt_next = '0;
        end
      end

      START: begin
        if (w_tick) begin
          w_state_next   = DATA;
          w_bit_cnt_next = '0;
        end
      end

      DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_cnt == C_LAST_DATA) begin
            w_state_next   = STOP;
            w_bit_cnt_next = '0;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end

      STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == C_LAST_STOP) begin
            w_state_next   = IDLE;
            w_bit_cnt_next = '0;
            w_done         = 1'b1;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Line level is computed from the next state so tx moves with the state.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign s_if.tx_ready = !w_busy;
  assign o_tx_busy     = w_busy;
  assign o_tx_done     = w_done;
  assign o_tx          = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx : directed, table-driven bench for uart_tx at two baud setups.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.DATA_BITS(8)) bus  ();
  uart_tx_if #(.DATA_BITS(8)) bus2 ();

  logic tx1, busy1, done1;
  logic tx2, busy2, done2;

  uart_tx dut (
    .clk       (clk),
    .rst       (rst),
    .s_if      (bus.slave),
    .o_tx      (tx1),
    .o_tx_busy (busy1),
    .o_tx_done (done1)
  );

  uart_tx #(
    .BAUD      (9600),
    .STOP_BITS (2)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .s_if      (bus2.slave),
    .o_tx      (tx2),
    .o_tx_busy (busy2),
    .o_tx_done (done2)
  );

  logic sel = 1'b0;
  logic m_tx, m_busy, m_done, m_ready;

  always_comb begin
    m_tx    = sel ? tx2 : tx1;
    m_busy  = sel ? busy2 : busy1;
    m_done  = sel ? done2 : done1;
    m_ready = sel ? bus2.tx_ready : bus.tx_ready;
  end

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_bits;
    int         exp_len;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    if (!sel) begin
      bus.tx_valid = v;
      bus.tx_data  = d;
    end else begin
      bus2.tx_valid = v;
      bus2.tx_data  = d;
    end
  endtask

  // k=0 is the first low cycle; bit i is sampled at cpb/2 + i*cpb.
  task automatic rx_frame(input int cpb, input int inj_k,
                          output logic [9:0] bits, output int done_k,
                          output int stop_high);
    int idx;
    bits      = '0;
    done_k    = -1;
    stop_high = 0;
    for (int w = 0; w < 4 && m_tx !== 1'b0; w++) tick();
    if (m_tx !== 1'b0) begin
      chk("start_seen", {31'd0, m_tx}, 32'd0);
      return;
    end
    for (int k = 0; k < cpb * 12; k++) begin
      if (k >= cpb / 2 && ((k - cpb / 2) % cpb) == 0) begin
        idx = (k - cpb / 2) / cpb;
        if (idx < 10) bits[idx] = m_tx;
      end
      if (k >= 9 * cpb && m_tx === 1'b1) stop_high++;
      if (inj_k >= 0 && k == inj_k)     drive(1'b1, 8'hFF);
      if (inj_k >= 0 && k == inj_k + 1) drive(1'b0, 8'hFF);
      if (m_done === 1'b1) begin
        done_k = k;
        break;
      end
      tick();
    end
    if (done_k < 0) chk("done_seen", 32'd0, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int cpb, input int stop_len);
    logic [9:0] bits;
    int         done_k, sh;
    drive(1'b1, v.data);
    tick();
    chk("start_latency", {31'd0, m_tx}, 32'd0);
    chk("ready_drop", {31'd0, m_ready}, 32'd0);
    chk("busy_set", {31'd0, m_busy}, 32'd1);
    drive(1'b0, 8'h00);
    rx_frame(cpb, -1, bits, done_k, sh);
    chk("frame_bits", {22'd0, bits}, {22'd0, v.exp_bits});
    chk("frame_len", done_k + 1, v.exp_len);
    chk("stop_len", sh, stop_len);
    tick();
    chk("ready_back", {31'd0, m_ready}, 32'd1);
    chk("busy_clear", {31'd0, m_busy}, 32'd0);
    chk("tx_idle", {31'd0, m_tx}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bits;
    int         done_k, sh, bad_tx, bad_rdy, bad_busy, n_done, n_low;

    // Expected mid-bit samples: bit0 = start, bits1..8 = data LSB first, bit9 = stop.
    vecs[0] = '{8'h55, 10'h2AA, 2170};
    vecs[1] = '{8'hA3, 10'h346, 2170};
    vecs[2] = '{8'h0F, 10'h21E, 2170};
    vecs[3] = '{8'h00, 10'h200, 2170};
    vecs[4] = '{8'hFF, 10'h3FE, 2170};
    vecs[5] = '{8'h3C, 10'h278, 2170};

    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus2.tx_valid = 1'b0;
    bus2.tx_data  = 8'h00;

    // Reset state and quiet idle.
    repeat (3) tick();
    chk("rst_tx", {31'd0, tx1}, 32'd1);
    chk("rst_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_done", {31'd0, done1}, 32'd0);
    rst = 1'b0;
    bad_tx = 0; bad_rdy = 0; bad_busy = 0; n_done = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (tx1 !== 1'b1) bad_tx++;
      if (bus.tx_ready !== 1'b1) bad_rdy++;
      if (busy1 !== 1'b0) bad_busy++;
      if (done1 !== 1'b0) n_done++;
    end
    chk("idle_tx", bad_tx, 0);
    chk("idle_ready", bad_rdy, 0);
    chk("idle_busy", bad_busy, 0);
    chk("idle_done", n_done, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 217, 217);

    // Back-to-back with tx_valid held: exactly one idle cycle between frames.
    drive(1'b1, 8'hA3);
    tick();
    chk("b2b_start1", {31'd0, tx1}, 32'd0);
    drive(1'b1, 8'h0F);
    rx_frame(217, -1, bits, done_k, sh);
    chk("b2b_bits1", {22'd0, bits}, 32'h346);
    chk("b2b_len1", done_k + 1, 2170);
    tick();
    chk("b2b_gap_tx", {31'd0, tx1}, 32'd1);
    chk("b2b_gap_ready", {31'd0, bus.tx_ready}, 32'd1);
    tick();
    chk("b2b_start2", {31'd0, tx1}, 32'd0);
    drive(1'b0, 8'h00);
    rx_frame(217, -1, bits, done_k, sh);
    chk("b2b_bits2", {22'd0, bits}, 32'h21E);
    chk("b2b_len2", done_k + 1, 2170);
    tick();

    // A valid pulse mid-frame is dropped, not queued.
    drive(1'b1, 8'h00);
    tick();
    drive(1'b0, 8'h00);
    rx_frame(217, 500, bits, done_k, sh);
    chk("ign_bits", {22'd0, bits}, 32'h200);
    n_low = 0; n_done = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (tx1 === 1'b0) n_low++;
      if (done1 === 1'b1) n_done++;
    end
    chk("ign_no_frame", n_low, 0);
    chk("ign_no_done", n_done, 0);

    // Asynchronous reset mid-frame.
    drive(1'b1, 8'h00);
    tick();
    drive(1'b0, 8'h00);
    repeat (500) tick();
    chk("pre_rst_low", {31'd0, tx1}, 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("async_tx", {31'd0, tx1}, 32'd1);
    chk("async_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("async_done", {31'd0, done1}, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    n_low = 0; n_done = 0;
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (tx1 === 1'b0) n_low++;
      if (done1 === 1'b1) n_done++;
    end
    chk("post_rst_low", n_low, 0);
    chk("post_rst_done", n_done, 0);
    chk("post_rst_ready", {31'd0, bus.tx_ready}, 32'd1);
    run_vec(vecs[5], 217, 217);

    // 9600 baud, two stop bits.
    sel = 1'b1;
    tick();
    run_vec('{8'h81, 10'h302, 28644}, 2604, 5208);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
